wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Parametrised write-back trace buffer for the MIPS core. Captures every register write-back event (destination register, result value) together with a cycle stamp, and queues the events in a FIFO for a debug consumer (UART/host drain logic) through a valid/ready interface. It generalises the single-event result/address observation currently available at the top of the MIPS core. It adds depth, configurable widths, R0 filtering, a stop-or-overwrite policy, cycle stamps and a drop counter.

## Interface

Parameters:
- DATA_W, 32, width of the write-back result.
- ADDR_W, 5, width of the destination register index.
- DEPTH, 16, number of FIFO entries; power of two, ≥2.
- STAMP_W, 16, width of the free-running cycle stamp.
- KEEP_R0, 0, when 0, events with address 0 are discarded silently and not counted as drops.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  capture enable; when 0, write-back events are ignored.
- i_mode  in  1  0 = stop when full (new events dropped), 1 = overwrite oldest.
- i_clear  in  1  synchronous flush of FIFO and drop counter.
- i_wb_valid  in  1  write-back event strobe from the pipeline.
- i_wb_addr  in  ADDR_W  destination register of the event.
- i_wb_data  in  DATA_W  result value of the event.
- i_ready  in  1  consumer accepts head entry.
- o_valid  out  1  head entry present (= not empty).
- o_addr  out  ADDR_W  head entry register index.
- o_data  out  DATA_W  head entry result.
- o_stamp  out  STAMP_W  head entry cycle stamp.
- o_count  out  $clog2(DEPTH)+1  entries stored.
- o_full  out  1  o_count == DEPTH.
- o_dropped  out  16  events lost, saturating at 0xFFFF.

## Operation

- Storage: register array of DEPTH entries {addr, data, stamp}; wr_ptr/rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH. o_count is tracked explicitly.
- Stamp counter: free-running, +1 every cycle, wraps modulo 2^STAMP_W. It is 0 after rst and is not affected by i_clear. The stored stamp is the counter value in the capture cycle.
- Capture condition: cap = i_wb_valid & i_enable & (KEEP_R0 | i_wb_addr != 0).
- Pop condition: pop = o_valid & i_ready.
- Per-cycle decision, applied in order:
  - rst: ptrs=0, count=0, dropped=0, stamp=0.
  - i_clear: ptrs=0, count=0, dropped=0. cap and pop in this cycle are ignored.
  - Not full, or pop asserted: cap writes at wr_ptr and advances wr_ptr. pop advances rd_ptr. count += cap − pop.
  - Full, no pop, i_mode=0: cap is discarded and dropped += 1 (saturating).
  - Full, no pop, i_mode=1: cap writes at wr_ptr, both ptrs advance, count stays DEPTH, dropped += 1 (the oldest entry is lost).
- Outputs are first-word-fall-through: o_addr/o_data/o_stamp = entry[rd_ptr]. These are don't-care when o_valid=0, but the bench expects the array contents (0 after reset).
- i_mode and i_enable may change on any cycle; they take effect in that same cycle.

## Timing

- Reset values: o_valid=0, o_count=0, o_full=0, o_dropped=0. o_addr/o_data/o_stamp=0 because the array is cleared on rst.
- Capture latency is 1 cycle. An event captured at edge N is visible on the outputs (o_valid=1 if the FIFO was empty) after edge N, so it can be popped at edge N+1.
- Pop takes effect at the edge where o_valid & i_ready; the next head entry appears after that edge.
- No combinational path from i_wb_* to any output. i_ready reaches no output combinationally.
- rst or i_clear asserted mid-burst: everything is discarded at that edge. A pop handshake in that same cycle does not count as delivered.

## Test plan

- Reset then idle: rst=1 for 3 cycles, then 0. Expect o_valid=0, o_count=0, o_dropped=0. Stamp of a capture 5 cycles after rst release is 5.
- Basic order: capture (3,0x11),(4,0x22),(5,0x33) on consecutive cycles with i_ready=0. Expect o_count=3. Then hold i_ready=1: expect data 0x11,0x22,0x33 on three consecutive cycles with stamps increasing by 1, then o_valid=0.
- R0 filter: KEEP_R0=0, capture (0,0xDEAD). Expect o_count unchanged and o_dropped unchanged. With KEEP_R0=1, the same event is stored.
- Stop mode: DEPTH=4, i_mode=0, capture 6 events with data 1..6 and no pop. Expect o_full=1, o_dropped=2, drain yields 1,2,3,4.
- Overwrite mode: the same stimulus with i_mode=1. Expect o_dropped=2, drain yields 3,4,5,6. A push together with a pop while full gives count=4 and no drop.
- Clear and saturation: with 3 entries queued, assert i_clear together with cap and pop. Expect o_count=0, o_dropped=0 next cycle, and the stamp is not reset. Forcing 70000 drops in stop mode gives o_dropped=0xFFFF.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures {dest reg, result, cycle stamp} into a FIFO
// drained by a debug consumer. Supports R0 filtering, stop or overwrite on full, and a drop counter.
module wb_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int KEEP_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic                     i_clear,
  input  logic                     i_wb_valid,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_data,
  output logic [STAMP_W-1:0]       o_stamp,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [15:0]              o_dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  mem_addr  [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        dropped;
  logic [STAMP_W-1:0] stamp;

  logic cap, pop, full;
  logic do_write, do_adv, do_drop;

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = (count != '0) & i_ready;
  assign cap  = i_wb_valid & i_enable & ((KEEP_R0 != 0) | (i_wb_addr != '0));

  // Overwrite on full is a write plus a read-pointer advance, so count holds at DEPTH.
  always_comb begin
    do_write = 1'b0;
    do_adv   = 1'b0;
    do_drop  = 1'b0;
    if (!full || pop) begin
      do_write = cap;
      do_adv   = pop;
    end else if (cap) begin
      do_drop  = 1'b1;
      do_write = i_mode;
      do_adv   = i_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stamp   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i]  <= '0;
        mem_data[i]  <= '0;
        mem_stamp[i] <= '0;
      end
    end else begin
      stamp <= stamp + 1'b1;
      if (i_clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        dropped <= '0;
      end else begin
        if (do_write) begin
          mem_addr[wr_ptr]  <= i_wb_addr;
          mem_data[wr_ptr]  <= i_wb_data;
          mem_stamp[wr_ptr] <= stamp;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (do_adv) rd_ptr <= rd_ptr + 1'b1;
        if (do_write && !do_adv)      count <= count + 1'b1;
        else if (!do_write && do_adv) count <= count - 1'b1;
        if (do_drop && dropped != 16'hFFFF) dropped <= dropped + 1'b1;
      end
    end
  end

  assign o_valid   = (count != '0);
  assign o_addr    = mem_addr[rd_ptr];
  assign o_data    = mem_data[rd_ptr];
  assign o_stamp   = mem_stamp[rd_ptr];
  assign o_count   = count;
  assign o_full    = full;
  assign o_dropped = dropped;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: ordering, R0 filter, stop/overwrite on full,
// clear behaviour and drop-counter saturation, with a KEEP_R0=1 twin for the R0 case.
module tb_wb_trace_buffer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 4;
  localparam int STAMP_W = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, i_enable, i_mode, i_clear, i_wb_valid, i_ready;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;

  logic               o_valid,  k_valid;
  logic [ADDR_W-1:0]  o_addr,   k_addr;
  logic [DATA_W-1:0]  o_data,   k_data;
  logic [STAMP_W-1:0] o_stamp,  k_stamp;
  logic [CW-1:0]      o_count,  k_count;
  logic               o_full,   k_full;
  logic [15:0]        o_dropped, k_dropped;

  int n_vec = 0;
  int n_err = 0;
  logic [STAMP_W-1:0] stamp_m;
  logic [STAMP_W-1:0] s_exp;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W), .KEEP_R0(0)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode), .i_clear(i_clear),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data), .o_stamp(o_stamp),
    .o_count(o_count), .o_full(o_full), .o_dropped(o_dropped)
  );

  wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W), .KEEP_R0(1)) dut_r0 (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode), .i_clear(i_clear),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_ready(i_ready),
    .o_valid(k_valid), .o_addr(k_addr), .o_data(k_data), .o_stamp(k_stamp),
    .o_count(k_count), .o_full(k_full), .o_dropped(k_dropped)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs and outputs are handled 1 time unit after the rising edge.
  task automatic step();
    if (rst) stamp_m = '0;
    else     stamp_m = stamp_m + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i_wb_valid = 1'b1;
    i_wb_addr  = a;
    i_wb_data  = d;
    step();
    i_wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_mode = 1'b0; i_clear = 1'b0;
    i_wb_valid = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_ready = 1'b0;
    stamp_m = '0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_valid",   o_valid,   0);
    chk("rst_count",   o_count,   0);
    chk("rst_full",    o_full,    0);
    chk("rst_dropped", o_dropped, 0);
    chk("rst_data",    o_data,    0);
    chk("rst_addr",    o_addr,    0);
    chk("rst_stamp",   o_stamp,   0);

    // Five idle cycles after release: the next capture carries stamp 5.
    repeat (5) step();
    ev(3, 32'h11);
    ev(4, 32'h22);
    ev(5, 32'h33);
    chk("order_count", o_count, 3);
    chk("order_d0",    o_data,  32'h11);
    chk("order_a0",    o_addr,  3);
    chk("order_s0",    o_stamp, 5);
    i_ready = 1'b1;
    step();
    chk("order_d1", o_data,  32'h22);
    chk("order_s1", o_stamp, 6);
    step();
    chk("order_d2", o_data,  32'h33);
    chk("order_s2", o_stamp, 7);
    step();
    chk("order_empty", o_valid, 0);
    i_ready = 1'b0;

    ev(0, 32'hDEAD);
    chk("r0_count",   o_count,   0);
    chk("r0_dropped", o_dropped, 0);
    chk("r0_keep_count", k_count, 1);
    chk("r0_keep_data",  k_data,  32'hDEAD);
    i_clear = 1'b1; step(); i_clear = 1'b0;

    i_mode = 1'b0;
    for (int i = 1; i <= 6; i++) ev(1, DATA_W'(i));
    chk("stop_full",    o_full,    1);
    chk("stop_count",   o_count,   4);
    chk("stop_dropped", o_dropped, 2);
    i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("stop_drain", o_data, 64'(i));
      step();
    end
    chk("stop_empty", o_valid, 0);
    i_ready = 1'b0;

    i_clear = 1'b1; step(); i_clear = 1'b0;
    chk("clr_dropped", o_dropped, 0);
    i_mode = 1'b1;
    for (int i = 1; i <= 6; i++) ev(1, DATA_W'(i));
    chk("ovw_count",   o_count,   4);
    chk("ovw_dropped", o_dropped, 2);
    chk("ovw_head",    o_data,    3);
    // Push while popping a full FIFO: no drop, count holds.
    i_ready = 1'b1;
    ev(1, 32'd7);
    chk("ovw_pp_count",   o_count,   4);
    chk("ovw_pp_dropped", o_dropped, 2);
    for (int i = 4; i <= 7; i++) begin
      chk("ovw_drain", o_data, 64'(i));
      step();
    end
    chk("ovw_empty", o_valid, 0);
    i_ready = 1'b0;

    i_mode = 1'b0;
    ev(2, 32'hA);
    ev(2, 32'hB);
    ev(2, 32'hC);
    chk("clr_pre_count",   o_count,   3);
    chk("clr_pre_dropped", o_dropped, 2);
    i_clear = 1'b1; i_ready = 1'b1;
    ev(2, 32'hD);
    i_clear = 1'b0; i_ready = 1'b0;
    chk("clr_count",   o_count,   0);
    chk("clr_drop0",   o_dropped, 0);
    chk("clr_valid",   o_valid,   0);
    s_exp = stamp_m;
    ev(6, 32'hE);
    chk("clr_stamp_kept", o_stamp, s_exp);
    chk("clr_post_data",  o_data,  32'hE);
    i_clear = 1'b1; step(); i_clear = 1'b0;

    i_mode = 1'b0;
    i_wb_valid = 1'b1; i_wb_addr = 1; i_wb_data = 32'h5A;
    repeat (65540) step();
    i_wb_valid = 1'b0;
    chk("sat_dropped", o_dropped, 16'hFFFF);
    chk("sat_count",   o_count,   4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
